// File: rtl/gjc_ser_pkg.sv
// Shared definitions for the GJC multi-channel serializer.
//   state_t     : control FSM states (IDLE, SHIFT)
//   WIDTH_MIN/MAX: legal serialisation ratio range
//   cnt_width() : bit counter width for a given word width
//   width_ok()  : range check used by the top-level elaboration assertion
package gjc_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/gjc_ser_lane.sv
// One serial lane: shifter, one-word hold register and registered output bit.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (output bit only)
//   enable       : clock-enable, low freezes the lane
//   load_new     : load word into the shifter, present its first bit
//   load_hold    : move the hold register into the shifter, present its first bit
//   advance      : present the next bit of the shifter
//   go_idle      : drive IDLE_VAL
//   hold_wr      : capture word into the hold register
//   word         : parallel word for this lane
//   bit_out      : registered serial output
module gjc_ser_lane
    import gjc_ser_pkg::*;
#(
    parameter int   WIDTH     = 4,
    parameter int   LSB_FIRST = 1,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load_new,
    input  logic             load_hold,
    input  logic             advance,
    input  logic             go_idle,
    input  logic             hold_wr,
    input  logic [WIDTH-1:0] word,
    output logic             bit_out
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    // The shifter keeps only the bits not yet presented; the bit on
    // bit_out has already been removed from it.
    function automatic logic [WIDTH-1:0] rest_bits(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_out <= IDLE_VAL;
        end else if (enable) begin
            if (load_new)
                bit_out <= first_bit(word);
            else if (load_hold)
                bit_out <= first_bit(hold);
            else if (advance)
                bit_out <= first_bit(shreg);
            else if (go_idle)
                bit_out <= IDLE_VAL;
        end
    end

    // Datapath registers carry no reset: their contents are only observed
    // after a load, and reset clears the flags that qualify them.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (load_new)
                shreg <= rest_bits(word);
            else if (load_hold)
                shreg <= rest_bits(hold);
            else if (advance)
                shreg <= rest_bits(shreg);

            if (hold_wr)
                hold <= word;
        end
    end

endmodule

// File: rtl/gjc_serializer_mc.sv
// Multi-channel parallel-to-serial output block with valid/ready load
// handshake and a one-word holding buffer for gap-free output.
// Ports:
//   clk_i    : clock
//   reset_n  : asynchronous active-low reset
//   enable   : global clock-enable, low freezes all state
//   data_i   : NUM_CH words, lane k at [k*WIDTH +: WIDTH]
//   valid_i  : data_i holds a word to load
//   ready_o  : a word can be accepted this cycle (combinational)
//   data_o   : registered serial bit per lane
//   frame_o  : high while data_o carries the first bit of a word
//   busy_o   : shifter or holding buffer occupied
module gjc_serializer_mc
    import gjc_ser_pkg::*;
#(
    parameter int   WIDTH     = 4,
    parameter int   NUM_CH    = 2,
    parameter int   LSB_FIRST = 1,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CH*WIDTH-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [NUM_CH-1:0]       data_o,
    output logic                    frame_o,
    output logic                    busy_o
);

    localparam int               CNT_W       = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(WIDTH - 1);
    localparam bit               WIDTH_LEGAL = width_ok(WIDTH);

    generate
        if (!WIDTH_LEGAL) begin : g_bad_width
            $error("gjc_serializer_mc: WIDTH must be in 2..16");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             hold_full;

    logic accept;
    logic last;
    logic load_new;
    logic load_hold;
    logic advance;
    logic go_idle;
    logic hold_wr;

    assign ready_o = enable & ~hold_full;
    assign accept  = valid_i & ready_o;
    assign last    = (state == SHIFT) && (bit_cnt == LAST_CNT);

    // Lane control decode. At the last bit a pending hold word wins; an
    // incoming word can only be taken directly when the hold is empty,
    // which ready_o already guarantees.
    always_comb begin
        load_new  = 1'b0;
        load_hold = 1'b0;
        advance   = 1'b0;
        go_idle   = 1'b0;
        hold_wr   = 1'b0;
        if (state == IDLE) begin
            load_new = accept;
        end else if (last) begin
            load_hold = hold_full;
            load_new  = ~hold_full & accept;
            go_idle   = ~hold_full & ~accept;
        end else begin
            advance = 1'b1;
            hold_wr = accept;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
            frame_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        frame_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end else begin
                        frame_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        bit_cnt <= '0;
                        if (hold_full || accept) begin
                            hold_full <= 1'b0;
                            frame_o   <= 1'b1;
                            busy_o    <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            frame_o <= 1'b0;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        frame_o <= 1'b0;
                        busy_o  <= 1'b1;
                        if (accept)
                            hold_full <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    frame_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        gjc_ser_lane #(
            .WIDTH     (WIDTH),
            .LSB_FIRST (LSB_FIRST),
            .IDLE_VAL  (IDLE_VAL)
        ) u_lane (
            .clk       (clk_i),
            .reset_n   (reset_n),
            .enable    (enable),
            .load_new  (load_new),
            .load_hold (load_hold),
            .advance   (advance),
            .go_idle   (go_idle),
            .hold_wr   (hold_wr),
            .word      (data_i[k*WIDTH +: WIDTH]),
            .bit_out   (data_o[k])
        );
    end

endmodule
